// File: rtl/add_seq_pkg.sv
// -----------------------------------------------------------------------------
// add_seq_pkg
// Shared types and constants for the add/display sequencing controller.
//   state_t           : operand-entry / add / convert / show FSM states
//   RESULT_W          : width of the adder result {C_OUT, SUM}
//   SEG_BLANK_DEFAULT : active-low pattern for a dark digit
//   SEG_DIGIT         : active-low 7-seg patterns for decimal digits 0..9
//   seg_decimal()     : decimal digit -> 7-seg pattern (dark if out of range)
// -----------------------------------------------------------------------------
package add_seq_pkg;

   typedef enum logic [2:0] {
      S_X,
      S_Y,
      S_ADD,
      S_CONV,
      S_SHOW
   } state_t;

   localparam int RESULT_W = 5;

   localparam logic [6:0] SEG_BLANK_DEFAULT = 7'b1111111;

   // Bit 6 is segment g, bit 0 is segment a; a 0 lights the segment.
   localparam logic [6:0] SEG_DIGIT [0:9] = '{
      7'b1000000,
      7'b1111001,
      7'b0100100,
      7'b0110000,
      7'b0011001,
      7'b0010010,
      7'b0000010,
      7'b1111000,
      7'b0000000,
      7'b0010000
   };

   function automatic logic [6:0] seg_decimal(input logic [3:0] d);
      if (d <= 4'd9) begin
         return SEG_DIGIT[d];
      end
      return SEG_BLANK_DEFAULT;
   endfunction

endpackage

// File: rtl/bcd_conv_seq.sv
// -----------------------------------------------------------------------------
// bcd_conv_seq
// Multi-cycle binary to tens/ones converter: subtracts 10 once per cycle.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : synchronous return to zero (tens, remainder)
//   start    : load value, zero tens, begin converting
//   value    : 5-bit binary input (0..31)
//   done     : high in the final conversion cycle (remainder below 10)
//   tens     : tens count so far, final when done is high
//   ones     : remainder low nibble, final when done is high
// Once done, the remainder register keeps the ones digit until clear/start.
// -----------------------------------------------------------------------------
module bcd_conv_seq
   import add_seq_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                clear,
   input  logic                start,
   input  logic [RESULT_W-1:0] value,
   output logic                done,
   output logic [1:0]          tens,
   output logic [3:0]          ones
);

   logic [RESULT_W-1:0] rem;
   logic                active;

   // done is combinational so the caller can leave its convert state in the
   // same cycle the remainder drops below 10.
   assign done = active && (rem < RESULT_W'(10));
   assign ones = rem[3:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem    <= '0;
         tens   <= '0;
         active <= 1'b0;
      end else if (clear) begin
         rem    <= '0;
         tens   <= '0;
         active <= 1'b0;
      end else if (start) begin
         rem    <= value;
         tens   <= '0;
         active <= 1'b1;
      end else if (active) begin
         if (rem >= RESULT_W'(10)) begin
            rem  <= rem - RESULT_W'(10);
            tens <= tens + 2'd1;
         end else begin
            active <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/rca_4bit.sv
// -----------------------------------------------------------------------------
// rca_4bit
// Four full adders chained through their carries.
//   a, b : 4-bit operands
//   cin  : carry into bit 0
//   sum  : 4-bit sum
//   cout : carry out of bit 3
// -----------------------------------------------------------------------------
module rca_4bit (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);

   // Unpacked so each carry is its own net rather than one self-feeding vector.
   logic carry [0:4];

   assign carry[0] = cin;

   for (genvar i = 0; i < 4; i++) begin : g_fa
      assign sum[i]       = a[i] ^ b[i] ^ carry[i];
      assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
   end

   assign cout = carry[4];

endmodule

// File: rtl/segment7.sv
// -----------------------------------------------------------------------------
// segment7
// Hex digit to active-low 7-segment decoder (bit 6 = g ... bit 0 = a).
//   hex : 4-bit value 0..F
//   seg : active-low segment pattern
// -----------------------------------------------------------------------------
module segment7 (
   input  logic [3:0] hex,
   output logic [6:0] seg
);

   always_comb begin
      seg = 7'b1111111;
      case (hex)
         4'h0: seg = 7'b1000000;
         4'h1: seg = 7'b1111001;
         4'h2: seg = 7'b0100100;
         4'h3: seg = 7'b0110000;
         4'h4: seg = 7'b0011001;
         4'h5: seg = 7'b0010010;
         4'h6: seg = 7'b0000010;
         4'h7: seg = 7'b1111000;
         4'h8: seg = 7'b0000000;
         4'h9: seg = 7'b0010000;
         4'hA: seg = 7'b0001000;
         4'hB: seg = 7'b0000011;
         4'hC: seg = 7'b1000110;
         4'hD: seg = 7'b0100001;
         4'hE: seg = 7'b0000110;
         4'hF: seg = 7'b0001110;
         default: seg = 7'b1111111;
      endcase
   end

endmodule

// File: rtl/add_seq_ctrl.sv
// -----------------------------------------------------------------------------
// add_seq_ctrl
// Push-button sequencer for the 4-bit ripple-carry adder and its display.
// Each button press steps: latch X, latch Y and carry-in, add, convert the
// 5-bit result to decimal tens/ones, show. Another press returns to X entry.
//   CLK, RST : clock, asynchronous active-high reset
//   SW       : operand switches
//   C_IN     : carry-in switch, latched with Y
//   BTN      : step button, asynchronous, active-high
//   X7, Y7   : active-low 7-seg of latched X / Y (hex)
//   OUT10    : active-low tens digit (dark unless showing)
//   OUT1     : active-low ones digit (dark unless showing)
//   BUSY     : high while adding / converting
//   DONE     : high while showing the result
// Build option: define DISP_HEX_EN to skip decimal conversion and show the
// carry-out as "0"/"1" on OUT10 and the 4-bit sum as a hex digit on OUT1.
// -----------------------------------------------------------------------------
module add_seq_ctrl
   import add_seq_pkg::*;
#(
   parameter int         SYNC_STAGES = 2,
   parameter logic [6:0] SEG_BLANK   = SEG_BLANK_DEFAULT
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [3:0] SW,
   input  logic       C_IN,
   input  logic       BTN,
   output logic [6:0] X7,
   output logic [6:0] Y7,
   output logic [6:0] OUT10,
   output logic [6:0] OUT1,
   output logic       BUSY,
   output logic       DONE
);

   // Fewer than two stages would not give the button metastability time.
   localparam int NSYNC = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

   logic [NSYNC-1:0] sync_ff;
   logic             sync_prev;
   logic             step;

   state_t state;
   state_t state_n;

   logic [3:0] x_reg;
   logic [3:0] y_reg;
   logic       cin_reg;

   logic [3:0] sum;
   logic       cout;

   logic [6:0] digit10;
   logic [6:0] digit1;

   // Synchronizer plus one extra flop; step is a single-cycle pulse per press.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sync_ff   <= '0;
         sync_prev <= 1'b0;
      end else begin
         sync_ff   <= {sync_ff[NSYNC-2:0], BTN};
         sync_prev <= sync_ff[NSYNC-1];
      end
   end

   assign step = sync_ff[NSYNC-1] & ~sync_prev;

   rca_4bit u_rca (
      .a    (x_reg),
      .b    (y_reg),
      .cin  (cin_reg),
      .sum  (sum),
      .cout (cout)
   );

   segment7 u_seg_x (
      .hex (x_reg),
      .seg (X7)
   );

   segment7 u_seg_y (
      .hex (y_reg),
      .seg (Y7)
   );

`ifdef DISP_HEX_EN
   logic [RESULT_W-1:0] result;
   logic [3:0]          hex_src;
   logic                carry_src;
   logic [6:0]          hex_seg;

   // Entering S_SHOW the result register is not loaded yet, so take the
   // adder directly; afterwards the registered copy keeps the display steady.
   assign hex_src   = (state == S_ADD) ? sum  : result[3:0];
   assign carry_src = (state == S_ADD) ? cout : result[4];

   segment7 u_seg_sum (
      .hex (hex_src),
      .seg (hex_seg)
   );

   assign digit10 = seg_decimal({3'b000, carry_src});
   assign digit1  = hex_seg;
`else
   logic       conv_start;
   logic       conv_clear;
   logic       conv_done;
   logic [1:0] conv_tens;
   logic [3:0] conv_ones;

   // The converter's remainder register doubles as the stored result.
   assign conv_start = (state == S_ADD);
   assign conv_clear = (state == S_SHOW) && step;

   bcd_conv_seq u_conv (
      .clk   (CLK),
      .rst   (RST),
      .clear (conv_clear),
      .start (conv_start),
      .value ({cout, sum}),
      .done  (conv_done),
      .tens  (conv_tens),
      .ones  (conv_ones)
   );

   assign digit10 = seg_decimal({2'b00, conv_tens});
   assign digit1  = seg_decimal(conv_ones);
`endif

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= S_X;
      end else begin
         state <= state_n;
      end
   end

   // Presses in S_ADD / S_CONV fall through the default hold and are lost.
   always_comb begin
      state_n = state;
      BUSY    = 1'b0;
      DONE    = 1'b0;
      case (state)
         S_X: begin
            if (step) state_n = S_Y;
         end
         S_Y: begin
            if (step) state_n = S_ADD;
         end
         S_ADD: begin
            BUSY = 1'b1;
`ifdef DISP_HEX_EN
            state_n = S_SHOW;
`else
            state_n = S_CONV;
`endif
         end
         S_CONV: begin
            BUSY = 1'b1;
`ifdef DISP_HEX_EN
            state_n = S_X;
`else
            if (conv_done) state_n = S_SHOW;
`endif
         end
         S_SHOW: begin
            DONE = 1'b1;
            if (step) state_n = S_X;
         end
         default: state_n = S_X;
      endcase
   end

   // Display digits are keyed off the next state so they light up on the
   // same edge that DONE rises and go dark on the edge that leaves S_SHOW.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         x_reg   <= '0;
         y_reg   <= '0;
         cin_reg <= 1'b0;
         OUT10   <= SEG_BLANK;
         OUT1    <= SEG_BLANK;
`ifdef DISP_HEX_EN
         result  <= '0;
`endif
      end else begin
         if ((state == S_X) && step) begin
            x_reg <= SW;
         end
         if ((state == S_Y) && step) begin
            y_reg   <= SW;
            cin_reg <= C_IN;
         end
`ifdef DISP_HEX_EN
         if (state == S_ADD) begin
            result <= {cout, sum};
         end else if ((state == S_SHOW) && step) begin
            result <= '0;
         end
`endif
         OUT10 <= (state_n == S_SHOW) ? digit10 : SEG_BLANK;
         OUT1  <= (state_n == S_SHOW) ? digit1  : SEG_BLANK;
      end
   end

endmodule

// File: tb/tb_add_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_add_seq_ctrl
// Directed bench for add_seq_ctrl. Expected display digits and busy-cycle
// counts are computed from the operands and queued when a run is driven,
// then popped and compared once the controller reports DONE.
// Honours DISP_HEX_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_add_seq_ctrl;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic [3:0] SW = 4'd0;
   logic       C_IN = 1'b0;
   logic       BTN = 1'b0;
   logic [6:0] X7;
   logic [6:0] Y7;
   logic [6:0] OUT10;
   logic [6:0] OUT1;
   logic       BUSY;
   logic       DONE;

   localparam logic [6:0] BLANK = 7'b1111111;

   typedef struct {
      logic [6:0] tens;
      logic [6:0] ones;
      int         busy;
   } exp_t;

   exp_t scoreboard[$];

   int nChecks = 0;
   int nFail   = 0;

   add_seq_ctrl #(
      .SYNC_STAGES (2),
      .SEG_BLANK   (7'b1111111)
   ) dut (
      .CLK   (CLK),
      .RST   (RST),
      .SW    (SW),
      .C_IN  (C_IN),
      .BTN   (BTN),
      .X7    (X7),
      .Y7    (Y7),
      .OUT10 (OUT10),
      .OUT1  (OUT1),
      .BUSY  (BUSY),
      .DONE  (DONE)
   );

   // 100 MHz-style free-running clock.
   always #5 CLK = ~CLK;

   // Hard stop if the directed sequence ever wedges.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: observed no end of test, expected finish before 500000");
      $fatal(1, "[TB] watchdog expired");
   end

   // Independent active-low reference table for hex digits.
   function automatic logic [6:0] segRef(input int d);
      case (d)
         0:  return 7'h40;
         1:  return 7'h79;
         2:  return 7'h24;
         3:  return 7'h30;
         4:  return 7'h19;
         5:  return 7'h12;
         6:  return 7'h02;
         7:  return 7'h78;
         8:  return 7'h00;
         9:  return 7'h10;
         10: return 7'h08;
         11: return 7'h03;
         12: return 7'h46;
         13: return 7'h21;
         14: return 7'h06;
         15: return 7'h0E;
         default: return 7'h7F;
      endcase
   endfunction

   task automatic checkOutput(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
      nChecks++;
      assert (observed === expected) else begin
         nFail++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Hold the button for n cycles, then release and let the synchronizer settle.
   task automatic pressButton(input int n);
      @(posedge CLK); #1;
      BTN = 1'b1;
      repeat (n) @(posedge CLK);
      #1;
      BTN = 1'b0;
      repeat (4) @(negedge CLK);
   endtask

   // One full X / Y+carry / add / show run starting from S_X. With dbl set the
   // Y press is followed by a second rising edge that lands during S_CONV.
   task automatic applyStimulus(input int x, input int y, input logic cin,
                                input bit dbl, input int xHold);
      int   r;
      int   busyCnt;
      bit   seen;
      exp_t e;

      r = x + y + int'(cin);
`ifdef DISP_HEX_EN
      e.tens = segRef(r / 16);
      e.ones = segRef(r % 16);
      e.busy = 1;
`else
      e.tens = segRef(r / 10);
      e.ones = segRef(r % 10);
      e.busy = 2 + r / 10;
`endif
      scoreboard.push_back(e);
      $display("[TB] run %0d + %0d + %0d", x, y, cin);

      SW = 4'(x);
      pressButton(xHold);
      checkOutput("x7_latched", 16'(X7), 16'(segRef(x)));
      checkOutput("busy_after_x", 16'(BUSY), 16'd0);
      checkOutput("done_after_x", 16'(DONE), 16'd0);

      SW      = 4'(y);
      C_IN    = cin;
      busyCnt = 0;
      seen    = 1'b0;
      for (int k = 0; k < 60 && !seen; k++) begin
         @(posedge CLK); #1;
         if (dbl) BTN = (k == 0 || k == 2 || k == 3);
         else     BTN = 1'b1;
         @(negedge CLK);
         if (BUSY) busyCnt++;
         if (DONE) seen = 1'b1;
      end
      BTN = 1'b0;
      checkOutput("done_reached", 16'(seen), 16'd1);

      repeat (4) @(negedge CLK);
      checkOutput("done_held", 16'(DONE), 16'd1);

      e = scoreboard.pop_front();
      checkOutput("busy_cycles", 16'(busyCnt), 16'(e.busy));
      checkOutput("out10", 16'(OUT10), 16'(e.tens));
      checkOutput("out1", 16'(OUT1), 16'(e.ones));
      checkOutput("y7_latched", 16'(Y7), 16'(segRef(y)));
   endtask

   // Press from S_SHOW back to operand entry; digits blank, operands held.
   task automatic returnToX(input int x, input int y);
      pressButton(3);
      checkOutput("done_cleared", 16'(DONE), 16'd0);
      checkOutput("out10_blank", 16'(OUT10), 16'(BLANK));
      checkOutput("out1_blank", 16'(OUT1), 16'(BLANK));
      checkOutput("x7_held", 16'(X7), 16'(segRef(x)));
      checkOutput("y7_held", 16'(Y7), 16'(segRef(y)));
   endtask

   initial begin
      int  busyCnt;
      bit  hit;
      int  target;
      int  rx;
      int  ry;
      bit  dblOk;

      $display("[TB] start");

      // Reset state, sampled while reset is held and again after release.
      RST = 1'b1;
      repeat (3) @(negedge CLK);
      checkOutput("rst_out10", 16'(OUT10), 16'(BLANK));
      checkOutput("rst_out1", 16'(OUT1), 16'(BLANK));
      checkOutput("rst_x7", 16'(X7), 16'h40);
      checkOutput("rst_y7", 16'(Y7), 16'h40);
      checkOutput("rst_busy", 16'(BUSY), 16'd0);
      checkOutput("rst_done", 16'(DONE), 16'd0);
      @(posedge CLK); #1;
      RST = 1'b0;
      repeat (3) @(negedge CLK);
      checkOutput("idle_busy", 16'(BUSY), 16'd0);
      checkOutput("idle_done", 16'(DONE), 16'd0);
      checkOutput("idle_out10", 16'(OUT10), 16'(BLANK));

      applyStimulus(9, 8, 1'b1, 1'b0, 3);
      returnToX(9, 8);

      applyStimulus(15, 15, 1'b1, 1'b0, 3);
      returnToX(15, 15);

      // Long hold on X must step only once; a second press edge lands in S_CONV.
`ifdef DISP_HEX_EN
      dblOk = 1'b0;
`else
      dblOk = 1'b1;
`endif
      applyStimulus(3, 15, 1'b1, dblOk, 50);
      returnToX(3, 15);

      // Reset in the middle of conversion.
`ifdef DISP_HEX_EN
      target = 1;
`else
      target = 3;
`endif
      $display("[TB] run 7 + 6 + 0 with reset during conversion");
      SW = 4'd7;
      pressButton(3);
      SW      = 4'd6;
      C_IN    = 1'b0;
      busyCnt = 0;
      hit     = 1'b0;
      @(posedge CLK); #1;
      BTN = 1'b1;
      for (int k = 0; k < 60 && !hit; k++) begin
         @(negedge CLK);
         if (BUSY) busyCnt++;
         if (busyCnt == target) hit = 1'b1;
      end
      checkOutput("midconv_reached", 16'(hit), 16'd1);
      RST = 1'b1;
      BTN = 1'b0;
      #1;
      checkOutput("midrst_busy", 16'(BUSY), 16'd0);
      checkOutput("midrst_done", 16'(DONE), 16'd0);
      checkOutput("midrst_out10", 16'(OUT10), 16'(BLANK));
      checkOutput("midrst_out1", 16'(OUT1), 16'(BLANK));
      checkOutput("midrst_x7", 16'(X7), 16'h40);
      checkOutput("midrst_y7", 16'(Y7), 16'h40);
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b0;
      repeat (3) @(negedge CLK);

      applyStimulus(0, 0, 1'b0, 1'b0, 3);
      returnToX(0, 0);

      // A few random operand sets.
      for (int n = 0; n < 4; n++) begin
         rx = int'($urandom_range(15, 0));
         ry = int'($urandom_range(15, 0));
         applyStimulus(rx, ry, 1'($urandom_range(1, 0)), 1'b0, 3);
         returnToX(rx, ry);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
